// File: rtl/id_ex_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_reg : single-entry ID/EX pipeline register with valid/ready         |
// |   handshake, flush, control sanitising and optional load-use detection    |
// |   (enable with macro ID_EX_LOAD_USE_DETECT_EN).                           |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module id_ex_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic        branch,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_funct3,
  input  logic [6:0]  id_funct7,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [1:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_branch,
  output logic        ex_mem_write,
  output logic        ex_mem_read,
  output logic        ex_mem_to_reg,
  output logic        ex_reg_write,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic        load_use_stall
);

  logic        r_valid;
  logic [1:0]  r_alu_op;
  logic        r_alu_src, r_branch, r_mem_write, r_mem_read, r_mem_to_reg, r_reg_write;
  logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;

  logic        w_hazard;
  logic        w_accept;
  logic [1:0]  w_alu_op;
  logic        w_alu_src, w_branch, w_mem_write, w_mem_read, w_reg_write, w_mem_to_reg;

  // Hazard term excludes id_valid so id_ready never depends on id_valid.
`ifdef ID_EX_LOAD_USE_DETECT_EN
  assign w_hazard = r_valid & r_mem_read & (r_rd != 5'd0) &
                    ((r_rd == id_rs1) | (r_rd == id_rs2));
`else
  assign w_hazard = 1'b0;
`endif

  assign load_use_stall = id_valid & w_hazard;
  assign id_ready       = (~r_valid | ex_ready) & ~w_hazard;
  assign w_accept       = id_valid & id_ready & ~flush;

  // Case-equality maps X/Z from the decoder to a clean 0.
  assign w_alu_op[0]  = (alu_op[0] === 1'b1);
  assign w_alu_op[1]  = (alu_op[1] === 1'b1);
  assign w_alu_src    = (alu_src   === 1'b1);
  assign w_branch     = (branch    === 1'b1);
  assign w_mem_write  = (mem_write === 1'b1);
  assign w_mem_read   = (mem_read  === 1'b1);
  assign w_reg_write  = (reg_write === 1'b1);
  assign w_mem_to_reg = (mem_to_reg === 1'b1) & w_reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_alu_op     <= 2'd0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_pc         <= 32'd0;
      r_rs1_data   <= 32'd0;
      r_rs2_data   <= 32'd0;
      r_imm        <= 32'd0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_funct7     <= 7'd0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_alu_op     <= w_alu_op;
      r_alu_src    <= w_alu_src;
      r_branch     <= w_branch;
      r_mem_write  <= w_mem_write;
      r_mem_read   <= w_mem_read;
      r_mem_to_reg <= w_mem_to_reg;
      r_reg_write  <= w_reg_write;
      r_pc         <= id_pc;
      r_rs1_data   <= id_rs1_data;
      r_rs2_data   <= id_rs2_data;
      r_imm        <= id_imm;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_rd         <= id_rd;
      r_funct3     <= id_funct3;
      r_funct7     <= id_funct7;
    end else if (flush | ex_ready) begin
      // Bubble: side-effecting controls cleared, data left stale.
      r_valid      <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_src    = r_alu_src;
  assign ex_branch     = r_branch;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_reg_write  = r_reg_write;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_funct3     = r_funct3;
  assign ex_funct7     = r_funct7;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_reg : table-driven bench for id_ex_reg plus directed sequences   |
// |   for reset, back-pressure and sanitising.                                |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_id_ex_reg;

`ifdef ID_EX_LOAD_USE_DETECT_EN
  localparam bit c_lud = 1'b1;
`else
  localparam bit c_lud = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_ready;
  logic [1:0]  alu_op = 2'd0;
  logic        alu_src = 1'b0, branch = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
  logic        mem_to_reg = 1'b0, reg_write = 1'b0;
  logic [31:0] id_pc = 32'd0, id_rs1_data = 32'd0, id_rs2_data = 32'd0, id_imm = 32'd0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic [2:0]  id_funct3 = 3'd0;
  logic [6:0]  id_funct7 = 7'd0;
  logic        ex_ready = 1'b1, flush = 1'b0;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_reg_write;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        load_use_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .mem_write(mem_write),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    logic        v, rdy, fl;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        mr, mw, rw, mtr;
    logic        e_idr, e_stall, e_val;
    logic [31:0] e_pc;
    logic        e_mr, e_mw, e_rw, e_mtr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, rdy, fl, input logic [31:0] pc,
                              input logic [4:0] rd, rs1, rs2, input logic mr, mw, rw, mtr,
                              input logic e_idr, e_stall, e_val, input logic [31:0] e_pc,
                              input logic e_mr, e_mw, e_rw, e_mtr);
    vec_t t;
    t.v = v; t.rdy = rdy; t.fl = fl; t.pc = pc; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.mr = mr; t.mw = mw; t.rw = rw; t.mtr = mtr;
    t.e_idr = e_idr; t.e_stall = e_stall; t.e_val = e_val; t.e_pc = e_pc;
    t.e_mr = e_mr; t.e_mw = e_mw; t.e_rw = e_rw; t.e_mtr = e_mtr;
    return t;
  endfunction

  task automatic drive(input logic v, rdy, fl, input logic [31:0] pc,
                       input logic [4:0] rd, rs1, rs2, input logic mr, mw, rw, mtr);
    id_valid = v; ex_ready = rdy; flush = fl; id_pc = pc;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = mtr;
    id_rs1_data = pc ^ 32'hA5A5_0000; id_imm = pc + 32'd4;
  endtask

  initial begin
    // Hazard-dependent rows fall back to plain pass-through when detection is off.
    vecs[0]  = mk(1,1,0, 32'h10, 3,1,2, 0,0,1,0,  1,0,1, 32'h10, 0,0,1,0);
    vecs[1]  = mk(1,1,0, 32'h14, 5,1,2, 1,0,1,1,  1,0,1, 32'h14, 1,0,1,1);
    vecs[2]  = mk(1,1,0, 32'h18, 6,5,2, 0,0,1,0,  !c_lud, c_lud, !c_lud, 32'h18, 0,0,!c_lud,0);
    vecs[3]  = mk(1,1,0, 32'h18, 6,5,2, 0,0,1,0,  1,0,1, 32'h18, 0,0,1,0);
    vecs[4]  = mk(1,1,0, 32'h1c, 0,0,2, 1,0,1,1,  1,0,1, 32'h1c, 1,0,1,1);
    vecs[5]  = mk(1,1,0, 32'h20, 7,0,0, 0,0,1,0,  1,0,1, 32'h20, 0,0,1,0);
    vecs[6]  = mk(1,1,1, 32'h24, 8,1,2, 0,1,1,0,  1,0,0, 32'h0,  0,0,0,0);
    vecs[7]  = mk(0,1,0, 32'h26, 8,1,2, 0,0,1,0,  1,0,0, 32'h0,  0,0,0,0);
    vecs[8]  = mk(1,1,0, 32'h28, 0,1,2, 0,1,0,1,  1,0,1, 32'h28, 0,1,0,0);
    vecs[9]  = mk(0,1,0, 32'h2c, 0,1,2, 0,0,0,0,  1,0,0, 32'h0,  0,0,0,0);
    vecs[10] = mk(1,1,0, 32'h30, 5,1,2, 1,0,1,1,  1,0,1, 32'h30, 1,0,1,1);
    vecs[11] = mk(1,0,0, 32'h34, 9,0,5, 0,0,1,0,  0,c_lud,1, 32'h30, 1,0,1,1);
    vecs[12] = mk(1,1,0, 32'h34, 9,0,5, 0,0,1,0,  !c_lud, c_lud, !c_lud, 32'h34, 0,0,!c_lud,0);

    // Reset state and first accept after release.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_ex_pc", ex_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rdy, vecs[i].fl, vecs[i].pc, vecs[i].rd, vecs[i].rs1,
            vecs[i].rs2, vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].mtr);
      #1;
      chk($sformatf("v%0d_id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].e_idr});
      chk($sformatf("v%0d_stall", i), {31'd0, load_use_stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_val});
      if (vecs[i].e_val)
        chk($sformatf("v%0d_ex_pc", i), ex_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_ctrl", i), {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
          {28'd0, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_rw, vecs[i].e_mtr});
    end

    // Back-pressure: entry A held three cycles while B waits.
    @(negedge clk);
    drive(1,1,0, 32'h40, 10,1,2, 0,0,1,0);
    @(posedge clk); #1;
    chk("bp_capture_a", ex_pc, 32'h40);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1,0,0, 32'h44, 11,1,2, 0,0,1,0);
      #1;
      chk($sformatf("bp%0d_id_ready", k), {31'd0, id_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_hold_pc", k), ex_pc, 32'h40);
      chk($sformatf("bp%0d_hold_rd", k), {27'd0, ex_rd}, 32'd10);
      chk($sformatf("bp%0d_valid", k), {31'd0, ex_valid}, 32'd1);
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    chk("bp_release_id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp_capture_b", ex_pc, 32'h44);
    chk("bp_capture_b_rd", {27'd0, ex_rd}, 32'd11);

    // Sanitise: X on mem_to_reg with reg_write=0, X on mem_write.
    @(negedge clk);
    drive(1,1,0, 32'h50, 12,1,2, 0,0,0,0);
    mem_to_reg = 1'bx;
    mem_write  = 1'bz;
    @(posedge clk); #1;
    chk("sanitise_mtr", {31'd0, ex_mem_to_reg}, 32'd0);
    chk("sanitise_mw", {31'd0, ex_mem_write}, 32'd0);
    chk("sanitise_valid", {31'd0, ex_valid}, 32'd1);

    // Asynchronous reset mid-cycle while FULL; an accept during reset is lost.
    @(negedge clk);
    drive(1,1,0, 32'h60, 13,1,2, 1,1,1,1);
    @(posedge clk); #1;
    chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_pc", ex_pc, 32'd0);
    chk("async_rst_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);
    chk("async_rst_rd", {27'd0, ex_rd}, 32'd0);
    @(posedge clk); #1;
    chk("rst_accept_lost", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,0, 32'h70, 14,1,2, 0,0,1,0);
    #1;
    chk("post_rst_id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_capture", ex_pc, 32'h70);
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
